// File: rtl/hwlp_ctrl.sv
// hwlp_ctrl: start/load/run/drain/done sequencer for the nested hardware loop unit.
// Optional feature macro HWLP_CTRL_PERF_EN adds perf_cycles_o (LOAD+RUN+DRAIN cycle count).
module hwlp_ctrl #(
   parameter int N_LP         = 4,
   parameter int NBIT_LP_IV   = 16,
   parameter int NBIT_II      = 4,
   parameter int DRAIN_CYCLES = 3,
   parameter int NBIT_ITER    = 32
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   output logic                       start_ready_o,
   input  logic                       abort_i,
   input  logic [NBIT_II-1:0]         cfg_ii_i,
   input  logic [N_LP*NBIT_LP_IV-1:0] cfg_iv_i,
   input  logic [N_LP*NBIT_LP_IV-1:0] cfg_fv_i,
   input  logic [N_LP*NBIT_LP_IV-1:0] cfg_inc_i,
   output logic                       hwlp_count_en_o,
   output logic [NBIT_II-1:0]         hwlp_ii_o,
   output logic [N_LP*NBIT_LP_IV-1:0] hwlp_iv_o,
   output logic [N_LP*NBIT_LP_IV-1:0] hwlp_fv_o,
   output logic [N_LP*NBIT_LP_IV-1:0] hwlp_inc_o,
   input  logic                       hwlp_valid_i,
   input  logic                       hwlp_end_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       aborted_o,
`ifdef HWLP_CTRL_PERF_EN
   output logic [NBIT_ITER-1:0]       perf_cycles_o,
`endif
   output logic [NBIT_ITER-1:0]       iter_cnt_o
);

   localparam int W        = N_LP * NBIT_LP_IV;
   localparam int NBIT_DRN = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
   localparam int DRN_LOAD = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e                state_q;
   logic                  count_en_q, done_q, aborted_q;
   logic [NBIT_II-1:0]    ii_q;
   logic [W-1:0]          iv_q, fv_q, inc_q;
   logic [NBIT_DRN-1:0]   drn_q;
   logic [NBIT_ITER-1:0]  iter_q, iter_d;
   logic                  start_acc;

   assign start_acc = (state_q == S_IDLE) && start_i;

   // NOTE: a combinational block assigns its default first, so no path leaves the output unassigned (no latch).
   always_comb begin
      iter_d = iter_q;
      if (start_acc)
         iter_d = '0;
      else if ((state_q == S_RUN) && hwlp_valid_i && !(&iter_q))
         iter_d = iter_q + NBIT_ITER'(1);
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         count_en_q <= 1'b0;
         done_q     <= 1'b0;
         aborted_q  <= 1'b0;
         // NOTE: shadow config registers are reset too; the loop unit must never see stale values.
         ii_q       <= '0;
         iv_q       <= '0;
         fv_q       <= '0;
         inc_q      <= '0;
         drn_q      <= '0;
         iter_q     <= '0;
      end else begin
         done_q    <= 1'b0;
         aborted_q <= 1'b0;
         iter_q    <= iter_d;
         unique case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  state_q <= S_LOAD;
                  ii_q    <= cfg_ii_i;
                  iv_q    <= cfg_iv_i;
                  fv_q    <= cfg_fv_i;
                  inc_q   <= cfg_inc_i;
               end
            end
            S_LOAD: begin
               if (abort_i) begin
                  state_q   <= S_IDLE;
                  aborted_q <= 1'b1;
               end else begin
                  state_q    <= S_RUN;
                  count_en_q <= 1'b1;
               end
            end
            S_RUN: begin
               // Abort wins over a simultaneous loop end.
               if (abort_i) begin
                  state_q    <= S_IDLE;
                  count_en_q <= 1'b0;
                  aborted_q  <= 1'b1;
               end else if (hwlp_end_i) begin
                  count_en_q <= 1'b0;
                  if (DRAIN_CYCLES == 0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_DRAIN;
                     drn_q   <= NBIT_DRN'(DRN_LOAD);
                  end
               end
            end
            S_DRAIN: begin
               if (abort_i) begin
                  state_q   <= S_IDLE;
                  aborted_q <= 1'b1;
               end else if (drn_q == '0) begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end else begin
                  drn_q <= drn_q - NBIT_DRN'(1);
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

`ifdef HWLP_CTRL_PERF_EN
   logic [NBIT_ITER-1:0] perf_q, perf_d;
   logic                 active;

   assign active = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_DRAIN);

   always_comb begin
      perf_d = perf_q;
      if (start_acc)
         perf_d = '0;
      else if (active && !(&perf_q))
         perf_d = perf_q + NBIT_ITER'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) perf_q <= '0;
      else       perf_q <= perf_d;
   end

   assign perf_cycles_o = perf_q;
`else
   // Performance counter not built.
`endif

   assign start_ready_o   = (state_q == S_IDLE);
   assign busy_o          = (state_q != S_IDLE);
   assign hwlp_count_en_o = count_en_q;
   assign done_o          = done_q;
   assign aborted_o       = aborted_q;
   assign hwlp_ii_o       = ii_q;
   assign hwlp_iv_o       = iv_q;
   assign hwlp_fv_o       = fv_q;
   assign hwlp_inc_o      = inc_q;
   assign iter_cnt_o      = iter_q;

endmodule

// File: tb/tb_hwlp_ctrl.sv
// Self-checking bench for hwlp_ctrl: vector table, directed corner sequences and a
// randomized run against a run-timeline reference model (age since start / since loop end).
module tb_hwlp_ctrl;

   localparam int N_LP = 4, NBIT_LP_IV = 16, NBIT_II = 4, DRAIN_CYCLES = 3, NBIT_ITER = 32;
   localparam int W = N_LP * NBIT_LP_IV;
   localparam longint unsigned SAT = (64'd1 << NBIT_ITER) - 64'd1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                 rst_i, start_i, abort_i, hwlp_valid_i, hwlp_end_i;
   logic [NBIT_II-1:0]   cfg_ii_i;
   logic [W-1:0]         cfg_iv_i, cfg_fv_i, cfg_inc_i;
   logic                 start_ready_o, hwlp_count_en_o, busy_o, done_o, aborted_o;
   logic [NBIT_II-1:0]   hwlp_ii_o;
   logic [W-1:0]         hwlp_iv_o, hwlp_fv_o, hwlp_inc_o;
   logic [NBIT_ITER-1:0] iter_cnt_o;
`ifdef HWLP_CTRL_PERF_EN
   logic [NBIT_ITER-1:0] perf_cycles_o;
`endif

   hwlp_ctrl #(
      .N_LP(N_LP), .NBIT_LP_IV(NBIT_LP_IV), .NBIT_II(NBIT_II),
      .DRAIN_CYCLES(DRAIN_CYCLES), .NBIT_ITER(NBIT_ITER)
   ) dut (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .start_ready_o(start_ready_o),
      .abort_i(abort_i), .cfg_ii_i(cfg_ii_i), .cfg_iv_i(cfg_iv_i), .cfg_fv_i(cfg_fv_i),
      .cfg_inc_i(cfg_inc_i), .hwlp_count_en_o(hwlp_count_en_o), .hwlp_ii_o(hwlp_ii_o),
      .hwlp_iv_o(hwlp_iv_o), .hwlp_fv_o(hwlp_fv_o), .hwlp_inc_o(hwlp_inc_o),
      .hwlp_valid_i(hwlp_valid_i), .hwlp_end_i(hwlp_end_i), .busy_o(busy_o),
      .done_o(done_o), .aborted_o(aborted_o),
`ifdef HWLP_CTRL_PERF_EN
      .perf_cycles_o(perf_cycles_o),
`endif
      .iter_cnt_o(iter_cnt_o)
   );

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a run is a timeline. m_age counts edges since start acceptance
   // (0 = LOAD), m_end_age counts edges since the loop end was taken (-1 = not yet).
   bit              m_active, m_abort;
   int              m_age, m_end_age;
   longint unsigned m_iter, m_perf;
   logic [NBIT_II-1:0] m_ii;
   logic [W-1:0]    m_iv, m_fv, m_inc;

   function automatic bit ph_load();  return m_active && m_age == 0; endfunction
   function automatic bit ph_run();   return m_active && m_age >= 1 && m_end_age < 0; endfunction
   function automatic bit ph_drain(); return m_active && m_end_age >= 0 && m_end_age < DRAIN_CYCLES; endfunction
   function automatic bit ph_done();  return m_active && m_end_age == DRAIN_CYCLES; endfunction

   task automatic model_edge();
      bit in_load, in_run, in_drain, in_done, working;
      in_load  = ph_load();
      in_run   = ph_run();
      in_drain = ph_drain();
      in_done  = ph_done();
      working  = in_load || in_run || in_drain;
      m_abort  = 1'b0;
      if (rst_i) begin
         m_active = 0; m_age = 0; m_end_age = -1; m_iter = 0; m_perf = 0;
         m_ii = '0; m_iv = '0; m_fv = '0; m_inc = '0;
      end else if (!m_active) begin
         if (start_i) begin
            m_active = 1; m_age = 0; m_end_age = -1; m_iter = 0; m_perf = 0;
            m_ii = cfg_ii_i; m_iv = cfg_iv_i; m_fv = cfg_fv_i; m_inc = cfg_inc_i;
         end
      end else begin
         if (working && m_perf < SAT) m_perf++;
         if (in_run && hwlp_valid_i && m_iter < SAT) m_iter++;
         if (working && abort_i) begin
            m_active = 0; m_abort = 1;
         end else if (in_done) begin
            m_active = 0;
         end else begin
            m_age++;
            if (in_run && hwlp_end_i) m_end_age = 0;
            else if (m_end_age >= 0)  m_end_age++;
         end
      end
   endtask

   task automatic compare_all();
      check("busy", busy_o, m_active);
      check("start_ready", start_ready_o, !m_active);
      check("count_en", hwlp_count_en_o, ph_run());
      check("done", done_o, ph_done());
      check("aborted", aborted_o, m_abort);
      check("iter_cnt", iter_cnt_o, m_iter);
      check("shadow_ii", hwlp_ii_o, m_ii);
      check("shadow_iv", hwlp_iv_o, m_iv);
      check("shadow_fv", hwlp_fv_o, m_fv);
      check("shadow_inc", hwlp_inc_o, m_inc);
`ifdef HWLP_CTRL_PERF_EN
      check("perf_cycles", perf_cycles_o, m_perf);
`endif
   endtask

   // One clock: model consumes the inputs the DUT samples, outputs checked 1ns after the edge.
   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic drive(input logic s, input logic v, input logic e, input logic a);
      start_i = s; hwlp_valid_i = v; hwlp_end_i = e; abort_i = a;
   endtask

   typedef struct {
      logic s, v, e, a;
      logic busy, cen, done;
      int   iter;
   } vec_t;

   vec_t tbl[9];
   int   n_done;
   logic [W-1:0] fv_a, fv_b;

   initial begin
      // Basic run: start, LOAD, two valid iterations, loop end, 3 drain cycles, DONE, IDLE.
      tbl[0] = '{s:1, v:0, e:0, a:0, busy:1, cen:0, done:0, iter:0};
      tbl[1] = '{s:0, v:0, e:0, a:0, busy:1, cen:1, done:0, iter:0};
      tbl[2] = '{s:0, v:1, e:0, a:0, busy:1, cen:1, done:0, iter:1};
      tbl[3] = '{s:0, v:1, e:0, a:0, busy:1, cen:1, done:0, iter:2};
      tbl[4] = '{s:0, v:0, e:1, a:0, busy:1, cen:0, done:0, iter:2};
      tbl[5] = '{s:0, v:0, e:0, a:0, busy:1, cen:0, done:0, iter:2};
      tbl[6] = '{s:0, v:0, e:0, a:0, busy:1, cen:0, done:0, iter:2};
      tbl[7] = '{s:0, v:0, e:0, a:0, busy:1, cen:0, done:1, iter:2};
      tbl[8] = '{s:0, v:0, e:0, a:0, busy:0, cen:0, done:0, iter:2};

      rst_i = 1'b1;
      drive(0, 0, 0, 0);
      cfg_ii_i = 4'd5; cfg_iv_i = {4{16'h1234}}; cfg_fv_i = {4{16'h00ff}}; cfg_inc_i = {4{16'h0002}};
      step();
      step();
      check("reset_busy", busy_o, 1'b0);
      check("reset_iter", iter_cnt_o, '0);
      check("reset_fv", hwlp_fv_o, '0);
      rst_i = 1'b0;
      step();

      // Table-driven basic run.
      cfg_ii_i = 4'd0; cfg_iv_i = '0; cfg_fv_i = 64'h0000_0000_0000_0001; cfg_inc_i = {4{16'h0001}};
      for (int i = 0; i < 9; i++) begin
         drive(tbl[i].s, tbl[i].v, tbl[i].e, tbl[i].a);
         step();
         check($sformatf("tbl%0d_busy", i), busy_o, tbl[i].busy);
         check($sformatf("tbl%0d_cen", i), hwlp_count_en_o, tbl[i].cen);
         check($sformatf("tbl%0d_done", i), done_o, tbl[i].done);
         check($sformatf("tbl%0d_iter", i), iter_cnt_o, tbl[i].iter);
      end
      check("basic_fv", hwlp_fv_o, 64'h0000_0000_0000_0001);

      // II spacing: ii=2, 4 iterations, last valid coincides with the loop end.
      cfg_ii_i = 4'd2; cfg_fv_i = 64'h0000_0000_0000_0003;
      drive(1, 0, 0, 0); step();
      drive(0, 0, 0, 0); step();
      check("ii_cen_first", hwlp_count_en_o, 1'b1);
      for (int k = 0; k < 12; k++) begin
         drive(0, (k % 3) == 2, k == 11, 0);
         step();
         if (k < 11) check("ii_cen_held", hwlp_count_en_o, 1'b1);
      end
      check("ii_cen_off", hwlp_count_en_o, 1'b0);
      drive(0, 0, 0, 0);
      n_done = 0;
      for (int k = 0; k < 10; k++) begin
         step();
         if (done_o) n_done++;
      end
      check("ii_iter", iter_cnt_o, 32'd4);
      check("ii_one_done", n_done, 1);
      check("ii_idle", busy_o, 1'b0);

      // Config isolation: cfg changes mid-RUN are invisible until the next start.
      fv_a = {16'h0004, 16'h0003, 16'h0002, 16'h0001};
      fv_b = {16'haaaa, 16'hbbbb, 16'hcccc, 16'hdddd};
      cfg_ii_i = 4'd1; cfg_fv_i = fv_a;
      drive(1, 0, 0, 0); step();
      drive(0, 0, 0, 0); step();
      cfg_ii_i = 4'd7; cfg_fv_i = fv_b;
      step(); step();
      check("iso_fv", hwlp_fv_o, fv_a);
      check("iso_ii", hwlp_ii_o, 4'd1);
      drive(0, 0, 1, 0); step();
      drive(0, 0, 0, 0);
      for (int k = 0; k < 5; k++) step();
      check("iso_fv_after_run", hwlp_fv_o, fv_a);
      drive(1, 0, 0, 0); step();
      check("iso_fv_new", hwlp_fv_o, fv_b);
      check("iso_ii_new", hwlp_ii_o, 4'd7);
      drive(0, 0, 0, 1); step();
      drive(0, 0, 0, 0); step();

      // Abort in the 5th RUN cycle together with the loop end.
      drive(1, 0, 0, 0); step();
      drive(0, 0, 0, 0); step();
      for (int k = 0; k < 4; k++) begin
         drive(0, 1, 0, 0); step();
      end
      drive(0, 0, 1, 1); step();
      check("abort_pulse", aborted_o, 1'b1);
      check("abort_cen", hwlp_count_en_o, 1'b0);
      check("abort_idle", busy_o, 1'b0);
      check("abort_iter_kept", iter_cnt_o, 32'd4);
      drive(0, 0, 0, 0);
      n_done = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (done_o) n_done++;
      end
      check("abort_no_done", n_done, 0);
      check("abort_single", aborted_o, 1'b0);

      // start_i held high: ignored while busy, new run accepted in the IDLE cycle after DONE.
      drive(1, 0, 0, 0); step();
      step();
      hwlp_valid_i = 1'b1; step();
      hwlp_valid_i = 1'b0; hwlp_end_i = 1'b1; step();
      hwlp_end_i = 1'b0;
      step(); step(); step();
      check("b2b_done", done_o, 1'b1);
      step();
      check("b2b_idle_ready", start_ready_o, 1'b1);
      check("b2b_idle_iter", iter_cnt_o, 32'd1);
      step();
      check("b2b_restart", busy_o, 1'b1);
      check("b2b_iter_clear", iter_cnt_o, 32'd0);
      drive(0, 0, 0, 1); step();
      drive(0, 0, 0, 0); step();

      // Synchronous reset in the middle of DRAIN.
      drive(1, 0, 0, 0); step();
      drive(0, 0, 0, 0); step();
      hwlp_valid_i = 1'b1; step();
      drive(0, 0, 1, 0); step();
      drive(0, 0, 0, 0); step();
      rst_i = 1'b1; step();
      rst_i = 1'b0;
      check("rst_mid_busy", busy_o, 1'b0);
      check("rst_mid_iter", iter_cnt_o, '0);
      check("rst_mid_inc", hwlp_inc_o, '0);
`ifdef HWLP_CTRL_PERF_EN
      check("rst_mid_perf", perf_cycles_o, '0);
`endif
      n_done = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (done_o) n_done++;
      end
      check("rst_mid_no_done", n_done, 0);

      // Randomized traffic against the reference model.
      for (int c = 0; c < 4000; c++) begin
         rst_i        = ($urandom_range(0, 299) == 0);
         start_i      = ($urandom_range(0, 3) == 0);
         abort_i      = ($urandom_range(0, 39) == 0);
         hwlp_end_i   = ($urandom_range(0, 11) == 0);
         hwlp_valid_i = abort_i ? 1'b0 : 1'($urandom_range(0, 1));
         cfg_ii_i     = 4'($urandom);
         cfg_iv_i     = {$urandom, $urandom};
         cfg_fv_i     = {$urandom, $urandom};
         cfg_inc_i    = {$urandom, $urandom};
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hwlp_ctrl.md
Name: hwlp_ctrl

Overview:
Sequencer for the 4-nested hardware loop unit. It accepts a start request with a loop configuration (II, per-loop iv/fv/inc) and snapshots that configuration into shadow registers. It holds the loop unit's count enable for the whole run, then detects loop termination and drains the downstream pipeline. It reports done, busy, abort and the number of issued iterations to the CSR/control layer.

Parameters:
N_LP, 4, number of nested loops
NBIT_LP_IV, 16, loop variable width
NBIT_II, 4, II field width (programmed as II-1)
DRAIN_CYCLES, 3, cycles to wait after loop end before done (0 = no drain)
NBIT_ITER, 32, iteration counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
start_i  in  1  start request, sampled only when start_ready_o=1
start_ready_o  out  1  high in IDLE
abort_i  in  1  abort current run
cfg_ii_i  in  NBIT_II  II-1
cfg_iv_i  in  N_LP*NBIT_LP_IV  initial values, loop i at bits [i*NBIT_LP_IV +: NBIT_LP_IV]
cfg_fv_i  in  N_LP*NBIT_LP_IV  final values, same packing
cfg_inc_i  in  N_LP*NBIT_LP_IV  increments, same packing
hwlp_count_en_o  out  1  count enable to loop unit
hwlp_ii_o  out  NBIT_II  shadow II
hwlp_iv_o / hwlp_fv_o / hwlp_inc_o  out  N_LP*NBIT_LP_IV  shadow config
hwlp_valid_i  in  1  loop unit valid (one per iteration)
hwlp_end_i  in  1  loop unit outermost-end pulse
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle completion pulse
aborted_o  out  1  one-cycle abort pulse
iter_cnt_o  out  NBIT_ITER  iterations issued in current/last run

Behaviour:
- Reset (rst_i=1 at clock edge): state IDLE, all shadow regs 0, hwlp_count_en_o=0, done_o=0, aborted_o=0, iter_cnt_o=0, drain counter 0.
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE: start_ready_o=1. If start_i=1, go to LOAD, latch all cfg_* into shadow regs, clear iter_cnt_o. start_i is ignored in every other state (no queueing).
- LOAD: one cycle; shadow outputs stable and count_en still 0, so the loop unit reloads iv. Go to RUN.
- RUN: hwlp_count_en_o=1, registered (high from the first RUN cycle through the last RUN cycle).
  - Each cycle with hwlp_valid_i=1: iter_cnt_o += 1, saturating at all-ones.
  - hwlp_end_i=1: go to DRAIN (or DONE if DRAIN_CYCLES=0); count_en deasserts the following cycle.
- DRAIN: count_en=0; counter loads DRAIN_CYCLES-1 on entry, decrements each cycle; at 0 go to DONE. Exactly DRAIN_CYCLES cycles in DRAIN.
- DONE: done_o=1 for exactly this cycle, then IDLE. First cycle after DONE accepts a new start.
- Shadow registers change only in the IDLE->LOAD transition; cfg_* changes while busy have no effect.
- Abort (abort_i=1 in LOAD, RUN or DRAIN): next state IDLE, count_en=0 next cycle, aborted_o=1 for one cycle (the cycle state returns to IDLE), no done_o. iter_cnt_o retains its value. abort_i in IDLE or DONE is ignored; DONE completes normally.
- Priority in RUN: abort_i over hwlp_end_i. Simultaneous hwlp_valid_i and hwlp_end_i: the iteration is counted, then the normal end transition is taken.
- Reset mid-run: immediate return to reset values; no done/aborted pulse.
- Latency: start_i accepted at edge N gives count_en=1 from cycle N+2. Loop end pulse at cycle M gives done_o at cycle M+1+DRAIN_CYCLES.

Optional Feature:
Macro HWLP_CTRL_PERF_EN.
- Defined: adds output perf_cycles_o (NBIT_ITER bits), counting cycles spent in LOAD+RUN+DRAIN of the current/last run. Cleared on start acceptance, saturating, frozen in IDLE, reset to 0.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Basic run: DRAIN_CYCLES=3; ii=0, loops fv=1/0/0/0, inc=1, iv=0; loop unit model produces 2 valid pulses then end -> iter_cnt_o=2, done_o exactly 4 cycles after the end pulse, busy_o low the cycle after done.
- II spacing: ii=2, 4 iterations -> count_en held continuously high across 12 cycles, iter_cnt_o=4, one done_o pulse.
- Config isolation: change cfg_fv_i and cfg_ii_i mid-RUN -> hwlp_fv_o and hwlp_ii_o unchanged until the next start.
- Abort: abort_i in the 5th RUN cycle together with hwlp_end_i -> aborted_o=1 once, no done_o, count_en 0 next cycle, state IDLE.
- Start while busy and back-to-back: start_i held high throughout -> ignored while busy; new run begins the cycle after DONE, with iter_cnt_o cleared to 0.
- Sync reset mid-DRAIN: rst_i pulsed -> all outputs at reset values on the next cycle, no done pulse; with HWLP_CTRL_PERF_EN, perf_cycles_o=0.
